trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 16 +
 rtl/trace_box_locator.sv | 40 ++++
 rtl/trace_capture.sv | 138 +++++++++++++
 tb/tb_trace_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture block: grid geometry,
// the capture FSM state encoding and the box-index type.
package trace_pkg;

    localparam int GRID_DIM  = 4;
    localparam int NUM_BOXES = GRID_DIM * GRID_DIM;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACING = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [3:0] box_idx_t;

endpackage

// File: rtl/trace_box_locator.sv
// Maps a cursor pixel position onto the 4x4 grid of boxes whose top-left
// corner is (initial_row, initial_col). Purely combinational.
module trace_box_locator
    import trace_pkg::*;
#(
    parameter int BOX_SIZE = 50
) (
    input  logic [8:0] cursor_row,
    input  logic [9:0] cursor_col,
    input  logic [7:0] initial_row,
    input  logic [8:0] initial_col,
    output box_idx_t   box_idx,
    output logic       in_grid
);

    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [10:0] GRID_SPAN = 11'(GRID_DIM * BOX_SIZE);

    logic [10:0] row_off;
    logic [10:0] col_off;
    logic [10:0] row_q;
    logic [10:0] col_q;

    // Offsets are formed one bit wider than needed; an underflow is caught by the
    // explicit cursor-before-origin compare, so the wrapped value is never used.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path
        // (here unconditionally) so no latch is inferred.
        row_off = {2'b00, cursor_row} - {3'b000, initial_row};
        col_off = {1'b0, cursor_col} - {2'b00, initial_col};
        row_q   = row_off / BOX_W;
        col_q   = col_off / BOX_W;
        in_grid = (cursor_row >= {1'b0, initial_row}) &&
                  (cursor_col >= {1'b0, initial_col}) &&
                  (row_off < GRID_SPAN) &&
                  (col_off < GRID_SPAN);
        box_idx = in_grid ? box_idx_t'(row_q * 11'(GRID_DIM) + col_q) : '0;
    end

endmodule

// File: rtl/trace_capture.sv
// Records which boxes of a 4x4 grid the player's cursor dwells in while
// the trace button is held. Optional feature macro: TRACE_ORDER_EN adds
// per-box step numbers on p1_order; without it p1_order is tied to 0.
module trace_capture
    import trace_pkg::*;
#(
    parameter int BOX_SIZE     = 50,
    parameter int DWELL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_screen_on,
    input  logic        clear,
    input  logic        pen_down,
    input  logic [8:0]  cursor_row,
    input  logic [9:0]  cursor_col,
    input  logic [7:0]  initial_row,
    input  logic [8:0]  initial_col,
    output logic [15:0] p1_traced,
    output logic [63:0] p1_order,
    output logic [5:0]  box_count,
    output logic        trace_done
);

    localparam int            CW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    box_idx_t      box_idx;
    box_idx_t      last_idx;
    logic          in_grid;
    logic          last_valid;
    logic          abort;
    logic          record;
    logic          hit;
    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] dwell_next;

    // Leaving the screen behaves exactly like an explicit clear.
    assign abort = clear | ~trace_screen_on;

    trace_box_locator #(
        .BOX_SIZE (BOX_SIZE)
    ) u_locator (
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .initial_row (initial_row),
        .initial_col (initial_col),
        .box_idx     (box_idx),
        .in_grid     (in_grid)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; abort outranks every other transition, including pen_down.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (pen_down)  state_next = TRACING;
                TRACING: if (!pen_down) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: trace_done pulses in the cycle the pen lifts during a trace.
    always_comb begin
        trace_done = (state == TRACING) && !pen_down && !abort;
    end

    // Dwell tracking: count consecutive cycles in one box, detect a new trace hit.
    always_comb begin
        dwell_next = '0;
        hit        = 1'b0;
        record     = (state == TRACING) && pen_down && !abort;
        if (record && in_grid) begin
            if (last_valid && (box_idx == last_idx))
                dwell_next = (dwell_cnt == DWELL_MAX) ? DWELL_MAX : dwell_cnt + 1'b1;
            hit = (dwell_next == DWELL_MAX) && !p1_traced[box_idx];
        end
    end

    // Trace mask, box count and dwell history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt  <= '0;
            last_idx   <= '0;
            last_valid <= 1'b0;
            p1_traced  <= '0;
            box_count  <= '0;
        end else begin
            dwell_cnt  <= dwell_next;
            last_idx   <= box_idx;
            last_valid <= record && in_grid;
            if (abort) begin
                p1_traced <= '0;
                box_count <= '0;
            end else if (hit) begin
                p1_traced[box_idx] <= 1'b1;
                if (box_count != 6'(NUM_BOXES))
                    box_count <= box_count + 6'd1;
            end
        end
    end

`ifdef TRACE_ORDER_EN
    logic [63:0] order_q;

    // Step-number nibbles; the 16th box does not fit in 1..15 and is written as 0.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the order nibbles are ordinary flops, so they take the async reset
        // like the rest of the visible state rather than being left uninitialised.
        if (reset) begin
            order_q <= '0;
        end else if (abort) begin
            order_q <= '0;
        end else if (hit) begin
            order_q[{box_idx, 2'b00} +: 4] <= (box_count < 6'd15) ? 4'(box_count + 6'd1) : 4'd0;
        end
    end

    assign p1_order = order_q;
`else
    assign p1_order = '0;
`endif

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (grid origin 190/270, 50 px boxes).
module tb_trace_capture;
    import trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_screen_on;
    logic        clear;
    logic        pen_down;
    logic [8:0]  cursor_row;
    logic [9:0]  cursor_col;
    logic [7:0]  initial_row;
    logic [8:0]  initial_col;
    logic [15:0] p1_traced;
    logic [63:0] p1_order;
    logic [5:0]  box_count;
    logic        trace_done;

    int checks      = 0;
    int failures    = 0;
    int done_pulses = 0;

    trace_capture #(
        .BOX_SIZE     (50),
        .DWELL_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .trace_screen_on (trace_screen_on),
        .clear           (clear),
        .pen_down        (pen_down),
        .cursor_row      (cursor_row),
        .cursor_col      (cursor_col),
        .initial_row     (initial_row),
        .initial_col     (initial_col),
        .p1_traced       (p1_traced),
        .p1_order        (p1_order),
        .box_count       (box_count),
        .trace_done      (trace_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trace_done === 1'b1) done_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_box(input int idx, input int n);
        cursor_row = 9'(200 + 50 * (idx / 4));
        cursor_col = 10'(280 + 50 * (idx % 4));
        repeat (n) step();
    endtask

    task automatic start_trace();
        clear           = 1'b0;
        trace_screen_on = 1'b1;
        pen_down        = 1'b1;
        cursor_row      = '0;
        cursor_col      = '0;
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL reset_mask got=%h want=0", p1_traced); end
        checks++; if (box_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", box_count); end
        checks++; if (p1_order !== 64'h0) begin failures++; $display("FAIL reset_order got=%h want=0", p1_order); end
        checks++; if (trace_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", trace_done); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_box();
        logic [63:0] exp_order;
`ifdef TRACE_ORDER_EN
        exp_order = 64'h1;
`else
        exp_order = 64'h0;
`endif
        start_trace();
        hold_box(0, 3);
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL single_3cyc got=%h want=0", p1_traced); end
        step();
        checks++; if (p1_traced !== 16'h0001) begin failures++; $display("FAIL single_mask got=%h want=0001", p1_traced); end
        checks++; if (box_count !== 6'd1) begin failures++; $display("FAIL single_count got=%0d want=1", box_count); end
        checks++; if (p1_order !== exp_order) begin failures++; $display("FAIL single_order got=%h want=%h", p1_order, exp_order); end
    endtask

    task automatic test_four_boxes();
        logic [63:0] exp_order;
        int          pulses_before;
`ifdef TRACE_ORDER_EN
        exp_order = 64'h0000_0430_0210_0000;
`else
        exp_order = 64'h0;
`endif
        do_clear();
        checks++; if (box_count !== 6'd0) begin failures++; $display("FAIL clear_count got=%0d want=0", box_count); end
        start_trace();
        hold_box(5, 4);
        hold_box(6, 4);
        hold_box(9, 4);
        hold_box(10, 4);
        checks++; if (p1_traced !== 16'h0660) begin failures++; $display("FAIL four_mask got=%h want=0660", p1_traced); end
        checks++; if (box_count !== 6'd4) begin failures++; $display("FAIL four_count got=%0d want=4", box_count); end
        pulses_before = done_pulses;
        pen_down = 1'b0;
        #1;
        checks++; if (trace_done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b want=1", trace_done); end
        step();
        checks++; if (trace_done !== 1'b0) begin failures++; $display("FAIL done_after got=%b want=0", trace_done); end
        checks++; if (dut.state !== DONE) begin failures++; $display("FAIL done_state got=%0d want=%0d", dut.state, DONE); end
        // Pen down in DONE over an untraced box must record nothing.
        pen_down = 1'b1;
        hold_box(0, 6);
        checks++; if (p1_traced !== 16'h0660) begin failures++; $display("FAIL done_hold_mask got=%h want=0660", p1_traced); end
        checks++; if (box_count !== 6'd4) begin failures++; $display("FAIL done_hold_count got=%0d want=4", box_count); end
        checks++; if (p1_order !== exp_order) begin failures++; $display("FAIL four_order got=%h want=%h", p1_order, exp_order); end
        checks++; if (done_pulses !== pulses_before + 1) begin failures++; $display("FAIL done_pulse_count got=%0d want=%0d", done_pulses - pulses_before, 1); end
    endtask

    task automatic test_short_dwell();
        do_clear();
        start_trace();
        hold_box(3, 3);
        cursor_row = '0;
        cursor_col = '0;
        step();
        hold_box(3, 3);
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL short_mask got=%h want=0", p1_traced); end
        checks++; if (box_count !== 6'd0) begin failures++; $display("FAIL short_count got=%0d want=0", box_count); end
        hold_box(3, 1);
        checks++; if (p1_traced !== 16'h0008) begin failures++; $display("FAIL short_then_full got=%h want=0008", p1_traced); end
    endtask

    task automatic test_reentry();
        logic [63:0] exp_order;
`ifdef TRACE_ORDER_EN
        exp_order = 64'h21;
`else
        exp_order = 64'h0;
`endif
        do_clear();
        start_trace();
        hold_box(0, 4);
        hold_box(1, 4);
        hold_box(0, 10);
        checks++; if (box_count !== 6'd2) begin failures++; $display("FAIL reentry_count got=%0d want=2", box_count); end
        checks++; if (p1_traced !== 16'h0003) begin failures++; $display("FAIL reentry_mask got=%h want=0003", p1_traced); end
        checks++; if (p1_order !== exp_order) begin failures++; $display("FAIL reentry_order got=%h want=%h", p1_order, exp_order); end
    endtask

    task automatic test_clear_and_reset();
        int pulses_before;
        // Clear together with pen_down, mid-trace.
        clear = 1'b1;
        #1;
        checks++; if (trace_done !== 1'b0) begin failures++; $display("FAIL clear_done got=%b want=0", trace_done); end
        step();
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL clear_mask got=%h want=0", p1_traced); end
        checks++; if (box_count !== 6'd0) begin failures++; $display("FAIL clear_cnt got=%0d want=0", box_count); end
        checks++; if (p1_order !== 64'h0) begin failures++; $display("FAIL clear_order got=%h want=0", p1_order); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL clear_state got=%0d want=%0d", dut.state, IDLE); end
        clear = 1'b0;
        step();
        hold_box(2, 4);
        checks++; if (p1_traced !== 16'h0004) begin failures++; $display("FAIL pre_reset_mask got=%h want=0004", p1_traced); end
        hold_box(1, 2);
        pulses_before = done_pulses;
        reset = 1'b1;
        #1;
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL rst_mask got=%h want=0", p1_traced); end
        checks++; if (box_count !== 6'd0) begin failures++; $display("FAIL rst_count got=%0d want=0", box_count); end
        checks++; if (p1_order !== 64'h0) begin failures++; $display("FAIL rst_order got=%h want=0", p1_order); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d want=%0d", dut.state, IDLE); end
        pen_down = 1'b0;
        #1;
        checks++; if (trace_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", trace_done); end
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (done_pulses !== pulses_before) begin failures++; $display("FAIL rst_pulses got=%0d want=%0d", done_pulses, pulses_before); end
    endtask

    task automatic test_outside();
        logic [63:0] exp_order;
`ifdef TRACE_ORDER_EN
        exp_order = 64'h0001_0000_0000_0000;
`else
        exp_order = 64'h0;
`endif
        do_clear();
        start_trace();
        cursor_row = 9'd189; cursor_col = 10'd280;
        repeat (10) step();
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL above_grid got=%h want=0", p1_traced); end
        cursor_row = 9'd200; cursor_col = 10'd269;
        repeat (10) step();
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL left_of_grid got=%h want=0", p1_traced); end
        cursor_row = 9'd390; cursor_col = 10'd280;
        repeat (10) step();
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL below_grid got=%h want=0", p1_traced); end
        cursor_row = 9'd389; cursor_col = 10'd280;
        repeat (4) step();
        checks++; if (p1_traced !== 16'h1000) begin failures++; $display("FAIL last_row_edge got=%h want=1000", p1_traced); end
        checks++; if (p1_order !== exp_order) begin failures++; $display("FAIL edge_order got=%h want=%h", p1_order, exp_order); end
    endtask

    task automatic test_screen_off();
        trace_screen_on = 1'b0;
        step();
        checks++; if (p1_traced !== 16'h0) begin failures++; $display("FAIL screen_off_mask got=%h want=0", p1_traced); end
        checks++; if (box_count !== 6'd0) begin failures++; $display("FAIL screen_off_count got=%0d want=0", box_count); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL screen_off_state got=%0d want=%0d", dut.state, IDLE); end
    endtask

    initial begin
        reset           = 1'b1;
        trace_screen_on = 1'b0;
        clear           = 1'b0;
        pen_down        = 1'b0;
        cursor_row      = '0;
        cursor_col      = '0;
        initial_row     = 8'd190;
        initial_col     = 9'd270;

        test_reset();
        test_single_box();
        test_four_boxes();
        test_short_dwell();
        test_reentry();
        test_clear_and_reset();
        test_outside();
        test_screen_off();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
